// File: rtl/wb_bus_if_pkg.sv
// Shared constants for the OpenMIPS memory-port to Wishbone B3 classic bridge.
// State encodings stay plain 2-bit constants so legacy netlists and probes still match.
package wb_bus_if_pkg;

    localparam logic [1:0] WB_IDLE       = 2'b00;
    localparam logic [1:0] WB_BUSY       = 2'b01;
    localparam logic [1:0] WB_WAIT_STALL = 2'b10;

    localparam int WB_ADDR_W_DEF  = 32;
    localparam int WB_DATA_W_DEF  = 32;
    localparam int WB_TIMEOUT_DEF = 255;

    // The counter must be able to hold TIMEOUT_CYC; a disabled timeout still needs one bit.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_bus_if.sv
// Bridges one OpenMIPS ce/we/sel/addr/data memory port onto a Wishbone B3 classic
// master, holding the pipeline stalled until the slave acks, errors or times out.
module wb_bus_if
    import wb_bus_if_pkg::*;
#(
    parameter int ADDR_W      = WB_ADDR_W_DEF,
    parameter int DATA_W      = WB_DATA_W_DEF,
    parameter int TIMEOUT_CYC = WB_TIMEOUT_DEF,
    localparam int SEL_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_ce_i,
    input  logic              cpu_we_i,
    input  logic [SEL_W-1:0]  cpu_sel_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic [DATA_W-1:0] cpu_data_o,

    input  logic              stall_i,
    input  logic              flush_i,
    output logic              stallreq_o,
    output logic              bus_err_o,

    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [SEL_W-1:0]  wb_sel_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    localparam int              CNT_W    = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rd_buf;

    logic busy;
    logic tmo;
    logic fin;
    logic fail;

    assign busy = (state == WB_BUSY);
    assign tmo  = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);
    // Flush outranks every completion source; error and timeout outrank ack.
    assign fin  = busy && !flush_i && (wb_ack_i || wb_err_i || tmo);
    assign fail = fin && (wb_err_i || tmo);

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        case (state)
            WB_IDLE: stallreq_o = cpu_ce_i && !flush_i;
            WB_BUSY: begin
                stallreq_o = !flush_i && !fin;
                if (fin && !fail && !wb_we_o)
                    cpu_data_o = wb_dat_i;
            end
            WB_WAIT_STALL: cpu_data_o = rd_buf;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= WB_IDLE;
            cnt       <= '0;
            rd_buf    <= '0;
            bus_err_o <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                WB_IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        state    <= WB_BUSY;
                        cnt      <= '0;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= cpu_we_i;
                        wb_sel_o <= cpu_sel_i;
                        wb_adr_o <= cpu_addr_i;
                        wb_dat_o <= cpu_data_i;
                    end
                end
                WB_BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (flush_i || fin) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= '0;
                    end
                    if (flush_i) begin
                        state <= WB_IDLE;
                    end else if (fin) begin
                        // Keep exactly what the CPU saw in the completion cycle (0 on error/write).
                        rd_buf    <= cpu_data_o;
                        bus_err_o <= fail;
                        state     <= stall_i ? WB_WAIT_STALL : WB_IDLE;
                    end
                end
                WB_WAIT_STALL: begin
                    if (!stall_i || flush_i)
                        state <= WB_IDLE;
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

endmodule
